// File: rtl/spm_1p_arb_pkg.sv
// Shared types and helpers for the single-port SPM arbiter.
package spm_1p_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/spm_rr_arbiter.sv
// Round-robin grant over NumReq requesters; prio names the highest-priority requester.
module spm_rr_arbiter #(
  parameter int NumReq = 2,
  localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [NumReq-1:0]   req_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic [IdxWidth-1:0] prio_q, prio_d;
  logic [IdxWidth-1:0] cand_idx;
  logic                found;
  int                  cand;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    prio_d   = prio_q;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (en_i) begin
      // Scan prio, prio+1, ... wrapping at NumReq (which need not be a power of two).
      for (int i = 0; i < NumReq; i++) begin
        cand = int'(prio_q) + i;
        if (cand >= NumReq) cand = cand - NumReq;
        cand_idx = IdxWidth'(cand);
        if (!found && req_i[cand_idx]) begin
          found           = 1'b1;
          gnt_o[cand_idx] = 1'b1;
          idx_o           = cand_idx;
          if (cand == NumReq - 1) prio_d = '0;
          else                    prio_d = cand_idx + IdxWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prio_q <= '0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/spm_1p_arbiter.sv
// Shares one single-port SPM between NumReq requesters with round-robin grant,
// optional zero-fill sweep after reset, and per-requester read-response routing.
module spm_1p_arbiter
  import spm_1p_arb_pkg::*;
#(
  parameter int NumReq    = 2,
  parameter int NumWords  = 1024,
  parameter int DataWidth = 128,
  parameter int ByteWidth = 8,
  parameter bit InitZero  = 1'b1,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth   = ceil_div(DataWidth, ByteWidth)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*BeWidth-1:0]     be_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          init_done_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  output logic [BeWidth-1:0]            mem_be_o,
  input  logic [DataWidth-1:0]          mem_rdata_i
);

  localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  arb_state_e          state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [NumReq-1:0]   rvalid_q, rvalid_d;
  logic [NumReq-1:0]   gnt;
  logic [IdxWidth-1:0] gnt_idx;

  logic [AddrWidth-1:0] addr_arr  [NumReq];
  logic [DataWidth-1:0] wdata_arr [NumReq];
  logic [BeWidth-1:0]   be_arr    [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr_i[gi*AddrWidth +: AddrWidth];
    assign wdata_arr[gi] = wdata_i[gi*DataWidth +: DataWidth];
    assign be_arr[gi]    = be_i[gi*BeWidth +: BeWidth];
  end

  spm_rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  ((state_q == RUN) && !rst_i),
    .req_i (req_i),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    // Memory port stays quiet while reset is held, whatever the state register says.
    if (!rst_i) begin
      case (state_q)
        INIT: begin
          if (InitZero) begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_be_o   = '1;
            mem_addr_o = cnt_q;
            cnt_d      = cnt_q + AddrWidth'(1);
            if (cnt_q == LastAddr) begin
              state_d = RUN;
              cnt_d   = '0;
            end
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (|gnt) begin
            mem_req_o   = 1'b1;
            mem_we_o    = we_i[gnt_idx];
            mem_addr_o  = addr_arr[gnt_idx];
            mem_wdata_o = wdata_arr[gnt_idx];
            mem_be_o    = be_arr[gnt_idx];
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  assign rvalid_d = gnt & ~we_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign gnt_o       = gnt;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = mem_rdata_i;
  assign init_done_o = (state_q == RUN) && !rst_i;

endmodule

// File: tb/tb_spm_1p_arbiter.sv
// Directed bench for spm_1p_arbiter: a zero-fill instance and a no-init instance, each with a RAM model.
module tb_spm_1p_arbiter;

  localparam int NR = 2;
  localparam int NW = 16;
  localparam int DW = 128;
  localparam int AW = 4;
  localparam int BW = 16;

  localparam logic [DW-1:0] DA5 = {16{8'hA5}};
  localparam logic [DW-1:0] D5A = {16{8'h5A}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: InitZero = 1
  logic              rst_a;
  logic [NR-1:0]     req_a, we_a, gnt_a, rvalid_a;
  logic [NR*AW-1:0]  addr_a;
  logic [NR*DW-1:0]  wdata_a;
  logic [NR*BW-1:0]  be_a;
  logic [DW-1:0]     rdata_a, mwdata_a, mrdata_a;
  logic              init_done_a, mreq_a, mwe_a;
  logic [AW-1:0]     maddr_a;
  logic [BW-1:0]     mbe_a;

  // Instance B: InitZero = 0
  logic              rst_b;
  logic [NR-1:0]     req_b, we_b, gnt_b, rvalid_b;
  logic [NR*AW-1:0]  addr_b;
  logic [NR*DW-1:0]  wdata_b;
  logic [NR*BW-1:0]  be_b;
  logic [DW-1:0]     rdata_b, mwdata_b, mrdata_b;
  logic              init_done_b, mreq_b, mwe_b;
  logic [AW-1:0]     maddr_b;
  logic [BW-1:0]     mbe_b;

  spm_1p_arbiter #(.NumReq(NR), .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .InitZero(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .we_i(we_a), .addr_i(addr_a), .wdata_i(wdata_a),
    .be_i(be_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .init_done_o(init_done_a),
    .mem_req_o(mreq_a), .mem_we_o(mwe_a), .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a),
    .mem_be_o(mbe_a), .mem_rdata_i(mrdata_a));

  spm_1p_arbiter #(.NumReq(NR), .NumWords(NW), .DataWidth(DW), .ByteWidth(8), .InitZero(1'b0)) dut_nz (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .we_i(we_b), .addr_i(addr_b), .wdata_i(wdata_b),
    .be_i(be_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .init_done_o(init_done_b),
    .mem_req_o(mreq_b), .mem_we_o(mwe_b), .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b),
    .mem_be_o(mbe_b), .mem_rdata_i(mrdata_b));

  // RAM models: 1-cycle read latency, byte-enabled writes; reset preloads a non-zero pattern.
  logic [DW-1:0] mem_a [NW];
  logic [DW-1:0] mem_b [NW];
  int wr_count_a = 0;

  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < NW; i++) mem_a[i] <= {16{8'hC3}};
    end else if (mreq_a) begin
      if (mwe_a) begin
        for (int k = 0; k < BW; k++)
          if (mbe_a[k]) mem_a[maddr_a][k*8 +: 8] <= mwdata_a[k*8 +: 8];
        wr_count_a <= wr_count_a + 1;
      end else begin
        mrdata_a <= mem_a[maddr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < NW; i++) mem_b[i] <= {16{8'(i + 'h30)}};
    end else if (mreq_b) begin
      if (mwe_b) begin
        for (int k = 0; k < BW; k++)
          if (mbe_b[k]) mem_b[maddr_b][k*8 +: 8] <= mwdata_b[k*8 +: 8];
      end else begin
        mrdata_b <= mem_b[maddr_b];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_a = 2'b11;
    cyc();
    cyc();
    #1;
    checks++;
    if (gnt_a !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt_a); end
    checks++;
    if (rvalid_a !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", rvalid_a); end
    checks++;
    if (init_done_a !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done_a); end
    checks++;
    if ({mreq_a, mwe_a, maddr_a, mwdata_a, mbe_a} !== '0) begin
      errors++; $display("FAIL reset_mem: req=%b we=%b addr=%0d be=%h want all zero", mreq_a, mwe_a, maddr_a, mbe_a);
    end
    $display("test_reset done");
  endtask

  task automatic sweep_check(input string name);
    int base;
    base = wr_count_a;
    for (int k = 0; k < NW; k++) begin
      #1;
      checks++;
      if (mreq_a !== 1'b1 || mwe_a !== 1'b1 || maddr_a !== AW'(k) || mwdata_a !== '0 ||
          mbe_a !== {BW{1'b1}} || gnt_a !== 2'b00 || init_done_a !== 1'b0) begin
        errors++;
        $display("FAIL %s_cycle%0d: req=%b we=%b addr=%0d be=%h gnt=%b done=%b want 1 1 %0d ffff 00 0",
                 name, k, mreq_a, mwe_a, maddr_a, mbe_a, gnt_a, init_done_a, k);
      end
      if (k == NW - 1) req_a = 2'b00;
      cyc();
    end
    #1;
    checks++;
    if (init_done_a !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", name, init_done_a); end
    checks++;
    if (mreq_a !== 1'b0) begin errors++; $display("FAIL %s_idle_req: got %b want 0", name, mreq_a); end
    checks++;
    if (wr_count_a - base !== NW) begin errors++; $display("FAIL %s_writes: got %0d want %0d", name, wr_count_a - base, NW); end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (mem_a[i] !== '0) begin errors++; $display("FAIL %s_mem%0d: got %h want 0", name, i, mem_a[i]); end
    end
    $display("%s sweep: %0d writes", name, wr_count_a - base);
  endtask

  task automatic test_init_sweep();
    rst_a = 1'b0;
    sweep_check("init_sweep");
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_gnt [4];
    logic [NR-1:0] exp_rv  [4];
    logic [DW-1:0] exp_rd  [4];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01};
    exp_rd  = '{'0, DA5, D5A, DA5};
    // Preload: requester 0 writes addr 3, requester 1 writes addr 7.
    req_a = 2'b11; we_a = 2'b11; addr_a = {4'd7, 4'd3}; wdata_a = {D5A, DA5}; be_a = '1;
    #1;
    checks++;
    if (gnt_a !== 2'b01 || maddr_a !== 4'd3) begin errors++; $display("FAIL fair_wr0: gnt=%b addr=%0d want 01 3", gnt_a, maddr_a); end
    cyc();
    req_a = 2'b10;
    #1;
    checks++;
    if (gnt_a !== 2'b10 || maddr_a !== 4'd7) begin errors++; $display("FAIL fair_wr1: gnt=%b addr=%0d want 10 7", gnt_a, maddr_a); end
    cyc();
    req_a = 2'b11; we_a = 2'b00;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (gnt_a !== exp_gnt[i]) begin errors++; $display("FAIL fair_gnt%0d: got %b want %b", i, gnt_a, exp_gnt[i]); end
      checks++;
      if (rvalid_a !== exp_rv[i]) begin errors++; $display("FAIL fair_rvalid%0d: got %b want %b", i, rvalid_a, exp_rv[i]); end
      if (i > 0) begin
        checks++;
        if (rdata_a !== exp_rd[i]) begin errors++; $display("FAIL fair_rdata%0d: got %h want %h", i, rdata_a, exp_rd[i]); end
      end
      $display("fairness cycle %0d: gnt=%b rvalid=%b", i, gnt_a, rvalid_a);
      cyc();
    end
    req_a = 2'b00;
    #1;
    checks++;
    if (gnt_a !== 2'b00 || rvalid_a !== 2'b10 || rdata_a !== D5A) begin
      errors++; $display("FAIL fair_tail: gnt=%b rvalid=%b rdata=%h want 00 10 %h", gnt_a, rvalid_a, rdata_a, D5A);
    end
    cyc();
  endtask

  task automatic test_write_then_read();
    req_a = 2'b01; we_a = 2'b01; addr_a = {4'd0, 4'd5};
    wdata_a = {{DW{1'b1}}, {96'h1111_2222_3333_4444_5555_6666, 32'hDEADBEEF}};
    be_a = {16'hFFFF, 16'h000F};
    #1;
    checks++;
    if (gnt_a !== 2'b01 || mwe_a !== 1'b1 || mbe_a !== 16'h000F) begin
      errors++; $display("FAIL wtr_write: gnt=%b we=%b be=%h want 01 1 000f", gnt_a, mwe_a, mbe_a);
    end
    cyc();
    req_a = 2'b10; we_a = 2'b00; addr_a = {4'd5, 4'd0};
    #1;
    checks++;
    if (gnt_a !== 2'b10 || mwe_a !== 1'b0 || maddr_a !== 4'd5) begin
      errors++; $display("FAIL wtr_read: gnt=%b we=%b addr=%0d want 10 0 5", gnt_a, mwe_a, maddr_a);
    end
    cyc();
    req_a = 2'b00;
    #1;
    checks++;
    if (rvalid_a !== 2'b10 || rdata_a !== {96'h0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wtr_rdata: rvalid=%b rdata=%h want 10 %h", rvalid_a, rdata_a, {96'h0, 32'hDEADBEEF});
    end
    $display("write_then_read: rdata=%h", rdata_a);
    cyc();
  endtask

  task automatic test_held_request();
    req_a = 2'b11; we_a = 2'b01; addr_a = {4'd3, 4'd8};
    wdata_a = {{DW{1'b0}}, {16{8'h77}}}; be_a = '1;
    #1;
    checks++;
    if (gnt_a !== 2'b01 || maddr_a !== 4'd8) begin errors++; $display("FAIL held_first: gnt=%b addr=%0d want 01 8", gnt_a, maddr_a); end
    cyc();
    req_a = 2'b10;
    #1;
    checks++;
    if (gnt_a !== 2'b10 || maddr_a !== 4'd3 || mwe_a !== 1'b0 || rvalid_a !== 2'b00) begin
      errors++; $display("FAIL held_second: gnt=%b addr=%0d we=%b rvalid=%b want 10 3 0 00", gnt_a, maddr_a, mwe_a, rvalid_a);
    end
    cyc();
    req_a = 2'b00;
    #1;
    checks++;
    if (rvalid_a !== 2'b10 || rdata_a !== DA5) begin
      errors++; $display("FAIL held_rvalid: rvalid=%b rdata=%h want 10 %h", rvalid_a, rdata_a, DA5);
    end
    $display("held_request: rvalid=%b", rvalid_a);
    cyc();
  endtask

  task automatic test_reset_mid_sweep();
    // Reset in the cycle of a granted read: the response must be dropped.
    req_a = 2'b10; we_a = 2'b00; addr_a = {4'd7, 4'd0};
    #1;
    checks++;
    if (gnt_a !== 2'b10) begin errors++; $display("FAIL rst_read_gnt: got %b want 10", gnt_a); end
    rst_a = 1'b1;
    #1;
    checks++;
    if (gnt_a !== 2'b00 || mreq_a !== 1'b0) begin errors++; $display("FAIL rst_read_gated: gnt=%b req=%b want 00 0", gnt_a, mreq_a); end
    cyc();
    req_a = 2'b00;
    #1;
    checks++;
    if (rvalid_a !== 2'b00 || init_done_a !== 1'b0) begin
      errors++; $display("FAIL rst_read_drop: rvalid=%b done=%b want 00 0", rvalid_a, init_done_a);
    end
    rst_a = 1'b0;
    for (int k = 0; k < 9; k++) cyc();
    #1;
    checks++;
    if (mreq_a !== 1'b1 || maddr_a !== 4'd9) begin errors++; $display("FAIL mid_sweep_addr: req=%b addr=%0d want 1 9", mreq_a, maddr_a); end
    rst_a = 1'b1;
    #1;
    checks++;
    if (mreq_a !== 1'b0) begin errors++; $display("FAIL mid_sweep_rst_req: got %b want 0", mreq_a); end
    cyc();
    #1;
    checks++;
    if (rvalid_a !== 2'b00 || init_done_a !== 1'b0) begin
      errors++; $display("FAIL mid_sweep_after: rvalid=%b done=%b want 00 0", rvalid_a, init_done_a);
    end
    rst_a = 1'b0;
    req_a = 2'b11;
    sweep_check("restart_sweep");
  endtask

  task automatic test_init_zero_off();
    req_b = 2'b00;
    rst_b = 1'b0;
    #1;
    checks++;
    if (init_done_b !== 1'b0 || mreq_b !== 1'b0) begin
      errors++; $display("FAIL nz_cycle0: done=%b req=%b want 0 0", init_done_b, mreq_b);
    end
    cyc();
    #1;
    checks++;
    if (init_done_b !== 1'b1) begin errors++; $display("FAIL nz_done: got %b want 1", init_done_b); end
    req_b = 2'b01; we_b = 2'b00; addr_b = {4'd0, 4'd2};
    #1;
    checks++;
    if (gnt_b !== 2'b01 || mreq_b !== 1'b1 || maddr_b !== 4'd2 || mwe_b !== 1'b0) begin
      errors++; $display("FAIL nz_gnt: gnt=%b req=%b addr=%0d we=%b want 01 1 2 0", gnt_b, mreq_b, maddr_b, mwe_b);
    end
    cyc();
    req_b = 2'b00;
    #1;
    checks++;
    if (rvalid_b !== 2'b01 || rdata_b !== {16{8'h32}}) begin
      errors++; $display("FAIL nz_rvalid: rvalid=%b rdata=%h want 01 %h", rvalid_b, rdata_b, {16{8'h32}});
    end
    $display("init_zero_off: rvalid=%b rdata=%h", rvalid_b, rdata_b);
  endtask

  initial begin
    rst_a = 1'b1; req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; be_a = '0;
    rst_b = 1'b1; req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; be_b = '0;
    test_reset();
    test_init_sweep();
    test_fairness();
    test_write_then_read();
    test_held_request();
    test_reset_mid_sweep();
    test_init_zero_off();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
